cordic_pipe: RTL and testbench

CORDIC_PIPE -- requirements
Module: cordic_pipe

---
 rtl/cordic_pkg.sv | 31 +++
 rtl/cordic_stage.sv | 59 +++++
 rtl/cordic_pipe.sv | 123 ++++++++++++
 tb/tb_cordic_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and payload types for the pipelined CORDIC rotator/vectorer.
package cordic_pkg;

    localparam int unsigned ANGLE_W = 32;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // Asymptotic CORDIC gain (~1.646760) in Q16; outputs are left uncompensated.
    localparam int unsigned CORDIC_K_Q16 = 107922;

    // round(atan(2^-i) / (2*pi) * 2^32): a full turn spans the 32-bit phase range.
    localparam logic [ANGLE_W-1:0] atan_tbl [0:31] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    // Control/phase payload that travels alongside x/y through every stage.
    typedef struct packed {
        logic               valid;
        logic               mode;
        logic [ANGLE_W-1:0] z;
    } cordic_ctl_t;

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation with a fixed shift index.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int unsigned SHIFT = 0,
    parameter int unsigned W     = 18
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  cordic_ctl_t         ctl_in,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    output cordic_ctl_t         ctl_out,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out
);

    localparam logic [ANGLE_W-1:0] ATAN = atan_tbl[SHIFT[4:0]];

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic signed [W-1:0] x_nxt;
    logic signed [W-1:0] y_nxt;
    logic [ANGLE_W-1:0]  z_nxt;
    logic                dir_pos;

    // Rotation drives z toward zero; vectoring drives y toward zero.
    always_comb begin
        x_sh    = x_in >>> SHIFT;
        y_sh    = y_in >>> SHIFT;
        dir_pos = (ctl_in.mode == MODE_ROT) ? ~ctl_in.z[ANGLE_W-1] : y_in[W-1];
        x_nxt   = x_in;
        y_nxt   = y_in;
        z_nxt   = ctl_in.z;
        if (dir_pos) begin
            x_nxt = x_in - y_sh;
            y_nxt = y_in + x_sh;
            z_nxt = ctl_in.z - ATAN;
        end else begin
            x_nxt = x_in + y_sh;
            y_nxt = y_in - x_sh;
            z_nxt = ctl_in.z + ATAN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctl_out <= '0;
            x_out   <= '0;
            y_out   <= '0;
        end else if (en) begin
            ctl_out <= '{valid: ctl_in.valid, mode: ctl_in.mode, z: z_nxt};
            x_out   <= x_nxt;
            y_out   <= y_nxt;
        end
    end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC: quadrant pre-rotation register followed by STAGES
// iteration stages; one sample per advancing clock, rotation or vectoring per sample.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int unsigned XY_SZ    = 16,
    parameter int unsigned STAGES   = 16,
    parameter int unsigned ANGLE_SZ = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic                    mode,
    input  logic [ANGLE_SZ-1:0]     angle,
    input  logic signed [XY_SZ-1:0] Xin,
    input  logic signed [XY_SZ-1:0] Yin,
    output logic                    out_valid,
    output logic                    mode_out,
    output logic signed [XY_SZ:0]   Xout,
    output logic signed [XY_SZ:0]   Yout,
    output logic [ANGLE_SZ-1:0]     Zout
);

    // Two guard bits: one so negating the most-negative input fits, one for growth.
    localparam int unsigned W = XY_SZ + 2;

    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] y_ext;
    logic signed [W-1:0] x_rot;
    logic signed [W-1:0] y_rot;
    logic [ANGLE_W-1:0]  z_rot;

    cordic_ctl_t         ctl_pre;
    logic signed [W-1:0] x_pre;
    logic signed [W-1:0] y_pre;

    cordic_ctl_t         ctl_s [0:STAGES-1];
    logic signed [W-1:0] x_s   [0:STAGES-1];
    logic signed [W-1:0] y_s   [0:STAGES-1];

    logic unused_msb;

    // Fold the input into the +/-90 degree range the iterations can converge over.
    always_comb begin
        x_ext = W'(Xin);
        y_ext = W'(Yin);
        x_rot = x_ext;
        y_rot = y_ext;
        z_rot = angle;
        if (mode == MODE_VEC) begin
            z_rot = '0;
            if (Xin[XY_SZ-1]) begin
                x_rot = -x_ext;
                y_rot = -y_ext;
                z_rot = 32'h8000_0000;
            end
        end else begin
            case (angle[ANGLE_SZ-1 -: 2])
                2'b01: begin
                    x_rot = -y_ext;
                    y_rot = x_ext;
                    z_rot = {2'b00, angle[ANGLE_SZ-3:0]};
                end
                2'b10: begin
                    x_rot = y_ext;
                    y_rot = -x_ext;
                    z_rot = {2'b11, angle[ANGLE_SZ-3:0]};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctl_pre <= '0;
            x_pre   <= '0;
            y_pre   <= '0;
        end else if (en) begin
            ctl_pre <= '{valid: in_valid, mode: mode, z: z_rot};
            x_pre   <= x_rot;
            y_pre   <= y_rot;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            cordic_stage #(.SHIFT(0), .W(W)) u_stage (
                .clock   (clock),
                .reset   (reset),
                .en      (en),
                .ctl_in  (ctl_pre),
                .x_in    (x_pre),
                .y_in    (y_pre),
                .ctl_out (ctl_s[0]),
                .x_out   (x_s[0]),
                .y_out   (y_s[0])
            );
        end else begin : g_next
            cordic_stage #(.SHIFT(i), .W(W)) u_stage (
                .clock   (clock),
                .reset   (reset),
                .en      (en),
                .ctl_in  (ctl_s[i-1]),
                .x_in    (x_s[i-1]),
                .y_in    (y_s[i-1]),
                .ctl_out (ctl_s[i]),
                .x_out   (x_s[i]),
                .y_out   (y_s[i])
            );
        end
    end

    // Last stage register is the output register; top guard bit is dropped.
    assign out_valid  = ctl_s[STAGES-1].valid;
    assign mode_out   = ctl_s[STAGES-1].mode;
    assign Zout       = ctl_s[STAGES-1].z;
    assign Xout       = x_s[STAGES-1][XY_SZ:0];
    assign Yout       = y_s[STAGES-1][XY_SZ:0];
    assign unused_msb = x_s[STAGES-1][W-1] ^ y_s[STAGES-1][W-1];

endmodule

// File: tb/tb_cordic_pipe.sv
// Scoreboard bench for cordic_pipe: trigonometric reference model, per-cycle valid timing.
module tb_cordic_pipe;
    import cordic_pkg::*;

    localparam int unsigned XY_SZ  = 16;
    localparam int unsigned STAGES = 16;
    localparam real XY_TOL      = 24.0;
    localparam real TWO_32      = 4294967296.0;
    localparam real PHASE_SCALE = 4294967296.0 / (2.0 * 3.14159265358979324);

    logic                    clock;
    logic                    reset;
    logic                    en;
    logic                    in_valid;
    logic                    mode;
    logic [31:0]             angle;
    logic signed [XY_SZ-1:0] Xin;
    logic signed [XY_SZ-1:0] Yin;
    logic                    out_valid;
    logic                    mode_out;
    logic signed [XY_SZ:0]   Xout;
    logic signed [XY_SZ:0]   Yout;
    logic [31:0]             Zout;

    cordic_pipe #(.XY_SZ(XY_SZ), .STAGES(STAGES), .ANGLE_SZ(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .mode      (mode),
        .angle     (angle),
        .Xin       (Xin),
        .Yin       (Yin),
        .out_valid (out_valid),
        .mode_out  (mode_out),
        .Xout      (Xout),
        .Yout      (Yout),
        .Zout      (Zout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        mode;
        real         ex;
        real         ey;
        logic [31:0] ez;
        real         ztol;
        longint      due;
    } exp_t;

    exp_t   sb [$];
    exp_t   hold_e;
    bit     hold_valid = 1'b0;
    bit     seen_edge  = 1'b0;
    bit     rst_edge   = 1'b0;
    bit     adv_edge   = 1'b0;
    longint adv_cnt    = 0;
    int     checks     = 0;
    int     failures   = 0;

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Product of the per-iteration stretch factors sqrt(1 + 2^-2i).
    function automatic real gain();
        real g = 1.0;
        for (int i = 0; i < int'(STAGES); i++)
            g = g * $sqrt(1.0 + 1.0 / real'(longint'(1) << (2 * i)));
        return g;
    endfunction

    function automatic exp_t model(input logic m, input logic [31:0] ang, input int x, input int y);
        exp_t e;
        real  g = gain();
        real  th;
        real  mag;
        real  ph;
        real  resid = 2.0 * PHASE_SCALE / real'(longint'(1) << (STAGES - 1)) + 64.0;
        e.mode = m;
        e.due  = 0;
        if (m == MODE_ROT) begin
            th     = real'(ang) / PHASE_SCALE;
            e.ex   = g * (real'(x) * $cos(th) - real'(y) * $sin(th));
            e.ey   = g * (real'(x) * $sin(th) + real'(y) * $cos(th));
            e.ez   = '0;
            e.ztol = resid;
        end else begin
            mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
            ph  = $atan2(real'(y), real'(x)) * PHASE_SCALE;
            if (ph < 0.0) ph = ph + TWO_32;
            e.ex   = g * mag;
            e.ey   = 0.0;
            e.ez   = 32'(longint'(ph));
            e.ztol = resid + PHASE_SCALE * XY_TOL / (g * mag);
        end
        return e;
    endfunction

    task automatic chk(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic check_sample(input string tag, input exp_t e);
        int zd;
        chk({tag, "_mode"}, mode_out == e.mode,
            $sformatf("mode_out=%0b required %0b", mode_out, e.mode));
        chk({tag, "_x"}, rabs(real'($signed(Xout)) - e.ex) <= XY_TOL,
            $sformatf("Xout=%0d required %0.1f", $signed(Xout), e.ex));
        chk({tag, "_y"}, rabs(real'($signed(Yout)) - e.ey) <= XY_TOL,
            $sformatf("Yout=%0d required %0.1f", $signed(Yout), e.ey));
        zd = int'(Zout - e.ez);
        chk({tag, "_z"}, rabs(real'(zd)) <= e.ztol,
            $sformatf("Zout=0x%08h required 0x%08h tol %0.0f", Zout, e.ez, e.ztol));
    endtask

    // Reference side: each accepted sample is due STAGES advancing edges after capture.
    always @(posedge clock) begin
        exp_t e;
        seen_edge = 1'b1;
        if (reset) begin
            sb.delete();
            rst_edge = 1'b1;
            adv_edge = 1'b0;
        end else begin
            rst_edge = 1'b0;
            adv_edge = en;
            if (en) begin
                adv_cnt++;
                if (in_valid) begin
                    e     = model(mode, angle, int'($signed(Xin)), int'($signed(Yin)));
                    e.due = adv_cnt + longint'(STAGES);
                    sb.push_back(e);
                end
            end
        end
    end

    // Monitor: sampled on the falling edge, away from register updates.
    always @(negedge clock) begin
        bit   exp_v;
        exp_t e;
        if (seen_edge) begin
            if (rst_edge) begin
                chk("reset_state", !out_valid && !mode_out && Xout == '0 && Yout == '0 && Zout == '0,
                    $sformatf("valid=%0b mode=%0b X=%0d Y=%0d Z=%0h required all zero",
                              out_valid, mode_out, $signed(Xout), $signed(Yout), Zout));
                hold_valid = 1'b0;
            end else if (adv_edge) begin
                exp_v = 1'b0;
                if (sb.size() > 0) exp_v = (sb[0].due == adv_cnt);
                chk("out_valid", out_valid == exp_v,
                    $sformatf("out_valid=%0b required %0b at advance %0d", out_valid, exp_v, adv_cnt));
                if (exp_v) begin
                    e = sb.pop_front();
                    check_sample("sample", e);
                    hold_e = e;
                end
                hold_valid = exp_v;
            end else begin
                chk("stall_valid", out_valid == hold_valid,
                    $sformatf("out_valid=%0b required %0b while stalled", out_valid, hold_valid));
                if (hold_valid) check_sample("stall", hold_e);
            end
        end
    end

    task automatic cyc(input bit r, input bit e, input bit v, input logic m,
                       input logic [31:0] a, input int x, input int y);
        @(negedge clock);
        reset    = r;
        en       = e;
        in_valid = v;
        mode     = m;
        angle    = a;
        Xin      = XY_SZ'(x);
        Yin      = XY_SZ'(y);
    endtask

    // Magnitudes bounded so K*|v| fits the output width; vectoring kept away from the origin.
    task automatic rand_xy(input logic m, output int x, output int y);
        x = int'($urandom_range(38000)) - 19000;
        y = int'($urandom_range(38000)) - 19000;
        if (m == MODE_VEC && (x < 6000 && x > -6000) && (y < 6000 && y > -6000))
            x = (x < 0) ? x - 6000 : x + 6000;
    endtask

    task automatic rand_cycles(input int n, input int stall_at);
        int x;
        int y;
        bit e;
        bit v;
        logic m;
        for (int k = 0; k < n; k++) begin
            e = ($urandom_range(99) < 85);
            if (k >= stall_at && k < stall_at + 5) e = 1'b0;
            v = ($urandom_range(99) < 80);
            m = 1'($urandom_range(1));
            rand_xy(m, x, y);
            cyc(1'b0, e, v, m, $urandom, x, y);
        end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        in_valid = 1'b1;
        mode     = MODE_ROT;
        angle    = '0;
        Xin      = XY_SZ'(1234);
        Yin      = '0;
        repeat (2) cyc(1'b1, 1'b1, 1'b1, MODE_ROT, 32'h0, 1234, 0);

        // Directed vectors, including most-negative inputs and quadrant folds.
        cyc(1'b0, 1'b1, 1'b1, MODE_ROT, 32'h0000_0000, 19429, 0);
        cyc(1'b0, 1'b1, 1'b1, MODE_ROT, 32'h4000_0000, 19429, 0);
        cyc(1'b0, 1'b1, 1'b1, MODE_ROT, 32'hA000_0000, 19429, 0);
        cyc(1'b0, 1'b1, 1'b1, MODE_VEC, 32'hDEAD_BEEF, -1000, 0);
        cyc(1'b0, 1'b1, 1'b1, MODE_VEC, 32'h1234_5678, -32768, 0);
        cyc(1'b0, 1'b1, 1'b1, MODE_ROT, 32'h4000_0000, 0, -32768);
        cyc(1'b0, 1'b1, 1'b0, MODE_ROT, 32'h0, 0, 0);
        cyc(1'b0, 1'b1, 1'b1, MODE_VEC, 32'h0, 3000, -4000);
        cyc(1'b0, 1'b1, 1'b1, MODE_ROT, 32'hC000_0000, 10000, 5000);
        repeat (STAGES + 2) cyc(1'b0, 1'b1, 1'b0, MODE_ROT, 32'h0, 0, 0);

        // Full circle of back-to-back rotations.
        for (int i = 0; i < 360; i++)
            cyc(1'b0, 1'b1, 1'b1, MODE_ROT, 32'((64'd4294967296 * 64'(i)) / 64'd360), 19429, 0);
        repeat (STAGES + 2) cyc(1'b0, 1'b1, 1'b0, MODE_ROT, 32'h0, 0, 0);

        // Mixed-mode random traffic with bubbles, random stalls and a 5-cycle stall.
        rand_cycles(400, 150);

        // Reset with the pipeline full: nothing in flight may emerge afterwards.
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b1, 1'b1, MODE_ROT, $urandom, 15000, -7000);
        cyc(1'b1, 1'b0, 1'b1, MODE_ROT, 32'h0, 100, 100);
        rand_cycles(80, 40);

        repeat (STAGES + 4) cyc(1'b0, 1'b1, 1'b0, MODE_ROT, 32'h0, 0, 0);
        @(negedge clock);
        chk("drain_empty", sb.size() == 0,
            $sformatf("%0d samples outstanding, required 0", sb.size()));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
